// File: rtl/cache_arbiter_rr_pkg.sv
// Shared types for the L1-to-L2 round-robin arbiter: default LC-3b word/line
// widths, arbiter FSM states and the latched operation type.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_l1_line;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

    localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/cache_arbiter_rr_select.sv
// Combinational round-robin picker: returns the first pending index found
// searching upward from ptr and wrapping at N-1.
module rr_select #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic          grant_valid,
    output logic [PW-1:0] grant_idx
);

    // Walk offsets from farthest to nearest so the nearest pending one wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (pending[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/cache_arbiter_rr.sv
// Round-robin arbiter between NUM_REQ L1 caches and one L2 port; a single
// transaction is outstanding at a time, with registered address/data/strobes.
module cache_arbiter_rr
    import lc3b_types::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = $bits(lc3b_word),
    parameter int LINE_WIDTH = $bits(lc3b_l1_line)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata,
    output logic [LINE_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            req_resp,
    output logic [ADDR_WIDTH-1:0]         l2_address,
    output logic [LINE_WIDTH-1:0]         l2_wdata,
    output logic                          l2_read,
    output logic                          l2_write,
    input  logic [LINE_WIDTH-1:0]         l2_rdata,
    input  logic                          l2_resp
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
        $error("cache_arbiter_rr: NUM_REQ must be in 2..%0d", ARB_MAX_REQ);
    end

    arb_state_t              state_q;
    arb_op_t                 op_q;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]           owner_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q, rdata_q;
    logic                    l2_read_q, l2_write_q;
    logic [NUM_REQ-1:0]      req_resp_q, resp_onehot_d;

    logic [NUM_REQ-1:0]      pending;
    logic                    grant_valid;
    logic [IW-1:0]           grant_idx;
    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [LINE_WIDTH-1:0]   wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = req_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
    end

    assign pending = req_read | req_write;

    rr_select #(
        .N (NUM_REQ)
    ) u_select (
        .pending     (pending),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign rr_ptr_d      = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign resp_onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_READ;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            req_resp_q <= '0;
        end else begin
            req_resp_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        // A simultaneous read+write from one requester is a write.
                        owner_q    <= grant_idx;
                        op_q       <= req_write[grant_idx] ? OP_WRITE : OP_READ;
                        addr_q     <= addr_arr[grant_idx];
                        wdata_q    <= wdata_arr[grant_idx];
                        l2_read_q  <= ~req_write[grant_idx];
                        l2_write_q <= req_write[grant_idx];
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (l2_resp) begin
                        if (op_q == OP_READ) begin
                            rdata_q <= l2_rdata;
                        end
                        l2_read_q  <= 1'b0;
                        l2_write_q <= 1'b0;
                        req_resp_q <= resp_onehot_d;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_rdata  = rdata_q;
    assign req_resp   = req_resp_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;
    assign l2_read    = l2_read_q;
    assign l2_write   = l2_write_q;

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Scoreboard bench for cache_arbiter_rr (NUM_REQ=4): directed transactions,
// an L2 model with programmable latency, and a monitor checking L2 issues and responses.
module tb_cache_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int LW = 128;

    localparam logic [LW-1:0] DEAD_LINE = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [LW-1:0] WR_LINE   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [LW-1:0] WR_LINE2  = 128'hFEED_FACE_CAFE_F00D_1357_9BDF_2468_ACE0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_read, req_write;
    logic [N*AW-1:0]   req_address;
    logic [N*LW-1:0]   req_wdata;
    logic [LW-1:0]     req_rdata;
    logic [N-1:0]      req_resp;
    logic [AW-1:0]     l2_address;
    logic [LW-1:0]     l2_wdata;
    logic              l2_read, l2_write;
    logic [LW-1:0]     l2_rdata;
    logic              l2_resp_m, stray;
    wire               l2_resp = l2_resp_m | stray;

    always #5 clk = ~clk;

    cache_arbiter_rr #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_rdata   (req_rdata),
        .req_resp    (req_resp),
        .l2_address  (l2_address),
        .l2_wdata    (l2_wdata),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_rdata    (l2_rdata),
        .l2_resp     (l2_resp)
    );

    typedef struct {
        logic [N-1:0]  resp;
        logic [LW-1:0] rdata;
    } resp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
        int            len;
    } iss_t;

    resp_t         resp_q[$];
    iss_t          iss_q[$];
    int            total = 0;
    int            bad = 0;
    int            l2_lat = 1;
    logic [N-1:0]  keep;
    logic [LW-1:0] last_rd;

    function automatic logic [LW-1:0] l2_line(input logic [AW-1:0] a);
        if (a == 16'h1230) return DEAD_LINE;
        return {8{a ^ 16'hA5A5}};
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return 16'h1000 | AW'(i << 4);
    endfunction

    function automatic logic [LW-1:0] wd_of(input int i);
        return {4{32'hC0DE_0000 | 32'(i)}};
    endfunction

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [LW-1:0] wd);
        req_read[i]             = rd;
        req_write[i]            = wr;
        req_address[i*AW +: AW] = a;
        req_wdata[i*LW +: LW]   = wd;
    endtask

    task automatic expect_txn(input int i, input logic wr, input logic [AW-1:0] a,
                              input logic [LW-1:0] wd, input int len);
        iss_t  it;
        resp_t r;
        it.addr  = a;
        it.wr    = wr;
        it.wdata = wd;
        it.len   = len;
        iss_q.push_back(it);
        if (!wr) last_rd = l2_line(a);
        r.resp  = N'(1) << i;
        r.rdata = last_rd;
        resp_q.push_back(r);
    endtask

    // Waits for n completions, dropping each finished requester unless it is kept busy.
    task automatic run(input int n, input int budget);
        int got;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (req_resp != '0) begin
                got++;
                for (int i = 0; i < N; i++) begin
                    if (req_resp[i] && !keep[i]) begin
                        req_read[i]  = 1'b0;
                        req_write[i] = 1'b0;
                    end
                end
            end
        end
        total++;
        if (got < n) begin
            bad++;
            $display("FAIL timeout: responses got=%0d required=%0d", got, n);
        end
        keep      = '0;
        req_read  = '0;
        req_write = '0;
        @(negedge clk);
    endtask

    // L2 model: responds once the strobe has been high for l2_lat cycles.
    initial begin
        int cnt;
        cnt       = 0;
        l2_resp_m = 1'b0;
        l2_rdata  = '0;
        forever begin
            @(negedge clk);
            if ((l2_read || l2_write) && !l2_resp_m) begin
                cnt++;
                if (cnt >= l2_lat) begin
                    l2_resp_m = 1'b1;
                    l2_rdata  = l2_line(l2_address);
                end
            end else begin
                l2_resp_m = 1'b0;
                cnt       = 0;
            end
        end
    end

    // Monitor: checks every L2 issue and every requester response against the queues.
    initial begin
        logic         prev_stb;
        logic         stb;
        logic [N-1:0] prev_resp;
        int           len;
        iss_t         cur;
        resp_t        r;
        prev_stb  = 1'b0;
        prev_resp = '0;
        len       = 0;
        cur.addr  = '0;
        cur.wr    = 1'b0;
        cur.wdata = '0;
        cur.len   = 0;
        forever begin
            @(negedge clk);
            stb = l2_read | l2_write;
            if (stb && !prev_stb) begin
                total++;
                len = 0;
                if (iss_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_issue: addr=%h rd=%b wr=%b", l2_address, l2_read, l2_write);
                end else begin
                    cur = iss_q.pop_front();
                    if (l2_write != cur.wr || l2_read != !cur.wr || l2_address != cur.addr || l2_wdata != cur.wdata) begin
                        bad++;
                        $display("FAIL issue: got addr=%h rd=%b wr=%b wdata=%h, need addr=%h wr=%b wdata=%h",
                                 l2_address, l2_read, l2_write, l2_wdata, cur.addr, cur.wr, cur.wdata);
                    end
                end
            end
            if (stb) begin
                len++;
                total++;
                if (l2_address != cur.addr || l2_wdata != cur.wdata) begin
                    bad++;
                    $display("FAIL issue_stable: got addr=%h need addr=%h", l2_address, cur.addr);
                end
            end
            if (!stb && prev_stb && cur.len != 0) begin
                total++;
                if (len != cur.len) begin
                    bad++;
                    $display("FAIL strobe_len: got %0d cycles need %0d", len, cur.len);
                end
            end
            if (req_resp != '0) begin
                total++;
                if (resp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_resp: req_resp=%b", req_resp);
                end else begin
                    r = resp_q.pop_front();
                    if (req_resp != r.resp || req_rdata != r.rdata) begin
                        bad++;
                        $display("FAIL resp: got resp=%b rdata=%h, need resp=%b rdata=%h",
                                 req_resp, req_rdata, r.resp, r.rdata);
                    end else begin
                        $display("txn ok: resp=%b rdata=%h", req_resp, req_rdata);
                    end
                end
                total++;
                if (prev_resp != '0) begin
                    bad++;
                    $display("FAIL resp_pulse: resp high two cycles, prev=%b now=%b", prev_resp, req_resp);
                end
            end
            prev_resp = req_resp;
            prev_stb  = stb;
        end
    end

    initial begin
        int order[5];
        iss_t it;
        req_read    = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        stray       = 1'b0;
        keep        = '0;
        last_rd     = '0;
        order       = '{0, 1, 2, 3, 0};

        repeat (2) @(negedge clk);
        total++;
        if (l2_read || l2_write || req_resp != '0 || l2_address != '0 || l2_wdata != '0 || req_rdata != '0) begin
            bad++;
            $display("FAIL reset_state: rd=%b wr=%b resp=%b addr=%h wdata=%h rdata=%h, need all 0",
                     l2_read, l2_write, req_resp, l2_address, l2_wdata, req_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: all four continuously requesting, latency 1.
        l2_lat = 1;
        keep   = '1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, addr_of(i), wd_of(i));
        for (int k = 0; k < 5; k++) expect_txn(order[k], 1'b0, addr_of(order[k]), wd_of(order[k]), 1);
        run(5, 60);

        // Single read, L2 latency 4.
        l2_lat = 4;
        set_req(0, 1'b1, 1'b0, 16'h1230, wd_of(0));
        expect_txn(0, 1'b0, 16'h1230, wd_of(0), 4);
        run(1, 40);

        // Single write from requester 1.
        l2_lat = 2;
        set_req(1, 1'b0, 1'b1, 16'h4440, WR_LINE);
        expect_txn(1, 1'b1, 16'h4440, WR_LINE, 2);
        run(1, 40);

        // Requester 2 alone moves the pointer to 3.
        l2_lat = 1;
        set_req(2, 1'b1, 1'b0, 16'h2220, wd_of(2));
        expect_txn(2, 1'b0, 16'h2220, wd_of(2), 1);
        run(1, 40);

        // Pointer at 3, only 1 and 3 pending: 3 then 1 (pointer ends at 2).
        set_req(1, 1'b1, 1'b0, 16'h3310, wd_of(1));
        set_req(3, 1'b1, 1'b0, 16'h3330, wd_of(3));
        expect_txn(3, 1'b0, 16'h3330, wd_of(3), 1);
        expect_txn(1, 1'b0, 16'h3310, wd_of(1), 1);
        run(2, 60);

        // Pointer at 2, 0 and 2 pending: 2 then 0.
        set_req(0, 1'b1, 1'b0, 16'h6600, wd_of(0));
        set_req(2, 1'b1, 1'b0, 16'h6620, wd_of(2));
        expect_txn(2, 1'b0, 16'h6620, wd_of(2), 1);
        expect_txn(0, 1'b0, 16'h6600, wd_of(0), 1);
        run(2, 60);

        // Read and write together is a write.
        l2_lat = 3;
        set_req(0, 1'b1, 1'b1, 16'h5550, WR_LINE2);
        expect_txn(0, 1'b1, 16'h5550, WR_LINE2, 3);
        run(1, 40);

        // Reset in the middle of ISSUE.
        l2_lat = 8;
        set_req(2, 1'b1, 1'b0, 16'h2220, wd_of(2));
        it.addr  = 16'h2220;
        it.wr    = 1'b0;
        it.wdata = wd_of(2);
        it.len   = 0;
        iss_q.push_back(it);
        repeat (3) @(negedge clk);
        total++;
        if (l2_read !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_read: l2_read=%b need 1", l2_read);
        end
        rst_n     = 1'b0;
        req_read  = '0;
        req_write = '0;
        #1;
        total++;
        if (l2_read || l2_write || req_resp != '0) begin
            bad++;
            $display("FAIL async_reset: rd=%b wr=%b resp=%b need 0", l2_read, l2_write, req_resp);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        last_rd = '0;
        stray   = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (l2_read || l2_write || req_resp != '0 || req_rdata != '0) begin
                bad++;
                $display("FAIL after_reset: rd=%b wr=%b resp=%b rdata=%h need 0",
                         l2_read, l2_write, req_resp, req_rdata);
            end
        end

        // Pointer back at 0: 0 beats 3.
        l2_lat = 1;
        set_req(3, 1'b1, 1'b0, 16'h7730, wd_of(3));
        set_req(0, 1'b1, 1'b0, 16'h7700, wd_of(0));
        expect_txn(0, 1'b0, 16'h7700, wd_of(0), 1);
        expect_txn(3, 1'b0, 16'h7730, wd_of(3), 1);
        run(2, 60);

        repeat (3) @(negedge clk);
        total++;
        if (resp_q.size() != 0 || iss_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending resp=%0d issue=%0d need 0", resp_q.size(), iss_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_arbiter_rr.md
Name: cache_arbiter_rr

Overview:
- Parametrised round-robin arbiter between NUM_REQ L1 caches and one shared L2 port. It replaces the fixed I-cache/D-cache two-way arbiter.
- Sits between the L1 caches (icache is requester 0, dcache is requester 1, further ports reserved for prefetch/victim buffers) and the L2 cache.
- Registers the L2 address, write data and read data.
- Owns the read/write strobes to L2 through an explicit FSM; the old design left these as external mux logic.

Parameters:
- NUM_REQ, 2, number of L1 requesters; legal range 2..8.
- ADDR_WIDTH, 16, address width (lc3b_word).
- LINE_WIDTH, 128, cache line width (lc3b_l1_line).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_read  in  NUM_REQ  per-requester read request.
- req_write  in  NUM_REQ  per-requester write request.
- req_address  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*LINE_WIDTH  packed write lines; same packing as req_address.
- req_rdata  out  LINE_WIDTH  registered read line, broadcast to all requesters.
- req_resp  out  NUM_REQ  one-hot, one-cycle completion pulse.
- l2_address  out  ADDR_WIDTH  registered address to L2.
- l2_wdata  out  LINE_WIDTH  registered write line to L2.
- l2_read  out  1  L2 read strobe.
- l2_write  out  1  L2 write strobe.
- l2_rdata  in  LINE_WIDTH  L2 read line, valid with l2_resp.
- l2_resp  in  1  L2 completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - FSM = IDLE.
  - rr_ptr = 0.
  - owner = 0, op = read.
  - All outputs 0: l2_read, l2_write, req_resp, l2_address, l2_wdata, req_rdata.
- Request visibility: requester i is pending when req_read[i] | req_write[i].
- Grant selection: the first pending index found searching upward and wrapping, starting at rr_ptr.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any request is pending, grant one at the clock edge.
  - At that edge, latch owner, latch op (write if req_write[owner], else read), latch l2_address from the owner's address, and latch l2_wdata from the owner's wdata. Then go to ISSUE.
  - If nothing is pending, stay in IDLE; outputs stay low and registers hold.
- ISSUE:
  - l2_read = (op==read) and l2_write = (op==write), both driven from registered state.
  - Hold until l2_resp=1.
  - On l2_resp: capture l2_rdata into req_rdata (reads only; hold it on writes), then go to RESP.
  - l2_address and l2_wdata are stable for the whole of ISSUE.
- RESP:
  - req_resp[owner] = 1 for exactly this cycle; req_rdata is valid.
  - rr_ptr <= (owner+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
  - Next state is IDLE.
- Requester contract:
  - Hold read/write, address and wdata stable from assertion until the cycle req_resp is seen.
  - Deassert on the edge following req_resp, so a request still high in IDLE is treated as new.
- Latency: request high at edge N gives l2_read/l2_write high in cycle N+1. If l2_resp arrives at edge M, req_resp is high in cycle M+1. Minimum 3 cycles request-to-resp.
- Conflicting request: req_read[i] and req_write[i] both high → treated as write. No error flagged.
- Requests arriving during ISSUE/RESP: not sampled; they wait for IDLE.
- Fairness: with all NUM_REQ requesting continuously, grant order is 0,1,...,NUM_REQ-1,0,...
  - No requester waits more than NUM_REQ-1 transactions.
- l2_resp outside ISSUE is ignored.
- Reset mid-transaction:
  - Immediately returns to IDLE; strobes drop and no req_resp is issued.
  - The requester must re-request after reset. L2 must tolerate an abandoned strobe.
- Only one transaction is outstanding at a time; there is no pipelining of L2 accesses.

Decomposition:
- Shared package (lc3b_types):
  - arb_state_t enum {IDLE, ISSUE, RESP}.
  - Existing lc3b_word / lc3b_l1_line for the default widths.
  - ARB_MAX_REQ = 8.
- Sub-module rr_select: combinational round-robin priority picker.
  - Parameter N.
  - Inputs: pending[N], ptr[$clog2(N)].
  - Outputs: grant_valid, grant_idx.
  - Reusable for future bus arbiters.
- Address/wdata registers and the FSM live in the top level.

Test Plan:
- Single read: req_read[0]=1 with addr 0x1230; L2 responds after 4 cycles with 0xDEAD...BEEF.
  → l2_read high 4 cycles at addr 0x1230; req_resp=2'b01 one cycle; req_rdata=0xDEAD...BEEF; back to IDLE.
- Single write: req_write[1]=1 with addr 0x4440 and wdata 0x0123...CDEF.
  → l2_write high, l2_read low; l2_wdata=0x0123...CDEF; req_resp=2'b10 one cycle.
- Contention, NUM_REQ=4: all requesters continuously requesting, L2 latency 1.
  → grant order 0,1,2,3,0; each req_resp one-hot in that sequence.
- Pointer wrap and skip, NUM_REQ=4: rr_ptr=3 with only requesters 1 and 3 pending.
  → 3 granted, then 1; rr_ptr becomes 0, then 2.
- Read+write conflict: req_read[0]=req_write[0]=1.
  → l2_write=1, l2_read=0.
- Reset mid-ISSUE: rst_n low for 1 cycle while l2_read=1.
  → l2_read drops asynchronously; req_resp stays 0; FSM in IDLE; rr_ptr=0.
  → Stray l2_resp the next cycle is ignored.
